// File: rtl/mem_burst_ctrl.sv
// Burst access sequencer in front of a single-port synchronous memory.
// Splits one command (start address, beats-1, direction) into single-word
// accesses, waits for mem_ready after each, streams read data out with a
// last-beat marker. At most one memory access is outstanding.
// Optional: MEM_BURST_BOUNDARY_CHECK_EN rejects bursts running past DEPTH-1
// (cmd_err pulse) instead of wrapping modulo DEPTH.
module mem_burst_ctrl #(
  parameter int DEPTH      = 1024,
  parameter int WIDTH      = 16,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int LEN_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_wr,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  input  logic                  wdata_valid,
  output logic                  wdata_ready,
  input  logic [WIDTH-1:0]      wdata,
  output logic                  rdata_valid,
  input  logic                  rdata_ready,
  output logic [WIDTH-1:0]      rdata,
  output logic                  rdata_last,
  output logic                  done,
  output logic                  busy,
  output logic                  cmd_err,
  output logic                  mem_valid,
  output logic                  mem_wr,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0]      mem_wdata,
  input  logic [WIDTH-1:0]      mem_rdata,
  input  logic                  mem_ready
);

  typedef enum logic [2:0] {IDLE, WR_DATA, ISSUE, RESP, RD_HOLD, DONE} state_t;

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] cur_addr, addr_inc;
  logic [LEN_WIDTH-1:0]  beats_left;
  logic                  dir;
  logic                  cmd_hs, cmd_bad;

  assign cmd_hs = cmd_valid && (state == IDLE);

  // next word address, wrapping at DEPTH even when DEPTH is not a power of two
  assign addr_inc = (cur_addr == ADDR_WIDTH'(DEPTH - 1)) ? '0 : cur_addr + 1'b1;

`ifdef MEM_BURST_BOUNDARY_CHECK_EN
  localparam int CW = ADDR_WIDTH + LEN_WIDTH + 1;
  logic [CW-1:0] span_end;

  // end address computed wide enough that the sum can never overflow
  always_comb begin
    span_end = CW'(cmd_addr) + CW'(cmd_len);
    cmd_bad  = span_end > CW'(DEPTH - 1);
  end

  // one-cycle rejection pulse; the command is consumed but nothing is issued
  always_ff @(posedge clk) begin
    if (reset) cmd_err <= 1'b0;
    else       cmd_err <= cmd_hs && cmd_bad;
  end
`else
  assign cmd_bad = 1'b0;
  assign cmd_err = 1'b0;
`endif

  // state register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cmd_hs && !cmd_bad) state_nxt = cmd_wr ? WR_DATA : ISSUE;
      WR_DATA: if (wdata_valid) state_nxt = ISSUE;
      ISSUE:   state_nxt = RESP;
      RESP:    if (mem_ready) begin
                 if (!dir)                 state_nxt = RD_HOLD;
                 else if (beats_left == 0) state_nxt = DONE;
                 else                      state_nxt = WR_DATA;
               end
      RD_HOLD: if (rdata_ready) state_nxt = rdata_last ? DONE : ISSUE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // outputs decoded from the state register only
  always_comb begin
    cmd_ready   = (state == IDLE);
    wdata_ready = (state == WR_DATA);
    mem_valid   = (state == ISSUE);
    done        = (state == DONE);
    busy        = (state != IDLE);
  end

  // burst counters, memory request fields and read-beat register
  always_ff @(posedge clk) begin
    if (reset) begin
      cur_addr    <= '0;
      beats_left  <= '0;
      dir         <= 1'b0;
      mem_wr      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      rdata       <= '0;
      rdata_valid <= 1'b0;
      rdata_last  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (cmd_hs) begin
          cur_addr   <= cmd_addr;
          beats_left <= cmd_len;
          dir        <= cmd_wr;
          if (!cmd_wr && !cmd_bad) begin
            mem_wr   <= 1'b0;
            mem_addr <= cmd_addr;
          end
        end
        WR_DATA: if (wdata_valid) begin
          mem_wr    <= 1'b1;
          mem_addr  <= cur_addr;
          mem_wdata <= wdata;
        end
        RESP: if (mem_ready) begin
          if (dir) begin
            if (beats_left != 0) begin
              cur_addr   <= addr_inc;
              beats_left <= beats_left - 1'b1;
            end
          end else begin
            rdata       <= mem_rdata;
            rdata_valid <= 1'b1;
            rdata_last  <= (beats_left == 0);
          end
        end
        RD_HOLD: if (rdata_ready) begin
          rdata_valid <= 1'b0;
          rdata_last  <= 1'b0;
          if (!rdata_last) begin
            cur_addr   <= addr_inc;
            beats_left <= beats_left - 1'b1;
            mem_wr     <= 1'b0;
            mem_addr   <= addr_inc;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_burst_ctrl.sv
// Directed bench for mem_burst_ctrl: behavioural memory, scoreboard queues of
// expected memory accesses and read beats, immediate-assertion checks.
module tb_mem_burst_ctrl;
  localparam int DEPTH = 1024, WIDTH = 16, AW = 10, LW = 8;

  logic clk = 0, reset = 1;
  logic cmd_valid = 0, cmd_ready, cmd_wr = 0;
  logic [AW-1:0] cmd_addr = '0;
  logic [LW-1:0] cmd_len = '0;
  logic wdata_valid = 0, wdata_ready;
  logic [WIDTH-1:0] wdata = '0;
  logic rdata_valid, rdata_ready = 0, rdata_last, done, busy, cmd_err;
  logic [WIDTH-1:0] rdata;
  logic mem_valid, mem_wr, mem_ready;
  logic [AW-1:0] mem_addr;
  logic [WIDTH-1:0] mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  mem_burst_ctrl #(.DEPTH(DEPTH), .WIDTH(WIDTH), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_wr(cmd_wr), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata),
    .rdata_valid(rdata_valid), .rdata_ready(rdata_ready), .rdata(rdata),
    .rdata_last(rdata_last), .done(done), .busy(busy), .cmd_err(cmd_err),
    .mem_valid(mem_valid), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready));

  function automatic logic [WIDTH-1:0] pat(input int a);
    return 16'h5000 ^ a[15:0];
  endfunction

  // memory model: registered read, ready the cycle after the access
  logic init_mem = 1;
  logic [WIDTH-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (init_mem) for (int i = 0; i < DEPTH; i++) mem[i] <= pat(i);
    if (reset) begin
      mem_ready <= 1'b0;
      mem_rdata <= '0;
    end else begin
      mem_ready <= mem_valid;
      if (mem_valid) begin
        if (mem_wr) mem[mem_addr] <= mem_wdata;
        mem_rdata <= mem[mem_addr];
      end
    end
  end

  typedef struct packed { logic wr; logic [AW-1:0] addr; logic [WIDTH-1:0] d; } macc_t;
  typedef struct packed { logic [WIDTH-1:0] d; logic last; } rbeat_t;
  macc_t  exp_mem[$];
  rbeat_t exp_rd[$];

  int n_pass = 0, n_tot = 0;
  int cyc = 0, mv_cnt = 0, done_cnt = 0, err_cnt = 0, last_mv = -1;
  logic gap_chk = 0;
  logic [WIDTH-1:0] last_wd = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tot++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: got %0h want %0h", tag, obs, expv);
  endtask

  // monitor: pops scoreboard entries when the DUT issues accesses / hands over beats
  always @(negedge clk) begin
    cyc++;
    if (!reset) begin
      if (mem_valid) begin
        mv_cnt++;
        chk("mem_expected", 32'(exp_mem.size() != 0), 1);
        if (exp_mem.size() != 0) begin
          macc_t e;
          e = exp_mem.pop_front();
          chk("mem_wr", 32'(mem_wr), 32'(e.wr));
          chk("mem_addr", 32'(mem_addr), 32'(e.addr));
          chk("mem_wdata", 32'(mem_wdata), 32'(e.d));
        end
        if (gap_chk && last_mv >= 0) chk("mv_gap", 32'(cyc - last_mv), 3);
        last_mv = cyc;
      end
      if (rdata_valid && rdata_ready) begin
        chk("rd_expected", 32'(exp_rd.size() != 0), 1);
        if (exp_rd.size() != 0) begin
          rbeat_t r;
          r = exp_rd.pop_front();
          chk("rdata", 32'(rdata), 32'(r.d));
          chk("rdata_last", 32'(rdata_last), 32'(r.last));
        end
      end
      if (done) done_cnt++;
      if (cmd_err) err_cnt++;
    end
  end

  task automatic send_cmd(input logic wr, input int addr, input int len);
    logic got = 0;
    @(posedge clk); #1;
    cmd_valid = 1; cmd_wr = wr; cmd_addr = AW'(addr); cmd_len = LW'(len);
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (cmd_ready) begin got = 1; break; end
    end
    chk("cmd_accept", 32'(got), 1);
    @(posedge clk); #1;
    cmd_valid = 0;
  endtask

  // call just after a posedge; returns just after the handshake edge
  task automatic send_wr(input logic [WIDTH-1:0] d);
    logic got = 0;
    wdata_valid = 1; wdata = d;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (wdata_ready) begin got = 1; break; end
    end
    chk("wdata_accept", 32'(got), 1);
    @(posedge clk); #1;
    last_wd = d;
  endtask

  task automatic wait_done(input string tag);
    logic got = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (done) begin got = 1; break; end
    end
    chk(tag, 32'(got), 1);
  endtask

  task automatic take_beat(input int hold);
    logic got = 0, stable = 1;
    logic [WIDTH-1:0] snap;
    logic snapl;
    int mv0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (rdata_valid) begin got = 1; break; end
    end
    chk("rd_valid_seen", 32'(got), 1);
    snap = rdata; snapl = rdata_last; mv0 = mv_cnt;
    if (hold > 0) begin
      for (int k = 0; k < hold; k++) begin
        @(negedge clk);
        if (!(rdata_valid && rdata == snap && rdata_last == snapl)) stable = 0;
      end
      chk("hold_stable", 32'(stable), 1);
      chk("hold_no_mem", 32'(mv_cnt - mv0), 0);
    end
    @(posedge clk); #1; rdata_ready = 1;
    @(posedge clk); #1; rdata_ready = 0;
  endtask

  initial begin
    int mv0, d0, e0, rdy_cnt;
    repeat (3) @(posedge clk);
    #1; reset = 0; init_mem = 0;
    @(negedge clk);
    // reset state
    chk("rst_ready", 32'(cmd_ready), 1);
    chk("rst_ctl", 32'({rdata_valid, rdata_last, done, busy, cmd_err, mem_valid, mem_wr, wdata_ready}), 0);
    chk("rst_data", {rdata, mem_wdata}, 0);
    chk("rst_addr", 32'(mem_addr), 0);

    // 1: write burst 0x010, 4 beats, data offered back to back
    for (int i = 0; i < 4; i++) exp_mem.push_back('{1'b1, AW'(16 + i), 16'hA001 + WIDTH'(i)});
    mv0 = mv_cnt; d0 = done_cnt; gap_chk = 1; last_mv = -1;
    send_cmd(1, 'h010, 3);
    for (int i = 0; i < 4; i++) send_wr(16'hA001 + WIDTH'(i));
    wdata_valid = 0;
    wait_done("wr_done");
    chk("wr_busy_at_done", 32'(busy), 1);
    gap_chk = 0;
    @(negedge clk);
    chk("wr_beats", 32'(mv_cnt - mv0), 4);
    chk("wr_done_once", 32'(done_cnt - d0), 1);
    chk("wr_idle", 32'({busy, done, cmd_ready}), 1);

    // 2: read-back, consumer always ready
    for (int i = 0; i < 4; i++) begin
      exp_mem.push_back('{1'b0, AW'(16 + i), last_wd});
      exp_rd.push_back('{16'hA001 + WIDTH'(i), i == 3});
    end
    rdata_ready = 1;
    send_cmd(0, 'h010, 3);
    wait_done("rd_done");
    chk("rd_all_beats", 32'(exp_rd.size()), 0);
    rdata_ready = 0;

    // 3: read with backpressure of 5 cycles on beat 2
    for (int i = 0; i < 4; i++) begin
      exp_mem.push_back('{1'b0, AW'(16 + i), last_wd});
      exp_rd.push_back('{16'hA001 + WIDTH'(i), i == 3});
    end
    send_cmd(0, 'h010, 3);
    take_beat(0); take_beat(5); take_beat(0); take_beat(0);
    wait_done("bp_done");

    // 4: burst crossing the top of memory
    mv0 = mv_cnt; d0 = done_cnt; e0 = err_cnt;
`ifdef MEM_BURST_BOUNDARY_CHECK_EN
    send_cmd(1, DEPTH - 2, 3);
    repeat (6) @(negedge clk);
    chk("bnd_err", 32'(err_cnt - e0), 1);
    chk("bnd_no_mem", 32'(mv_cnt - mv0), 0);
    chk("bnd_no_done", 32'(done_cnt - d0), 0);
    chk("bnd_idle", 32'(cmd_ready), 1);
`else
    exp_mem.push_back('{1'b1, AW'(DEPTH - 2), 16'hB001});
    exp_mem.push_back('{1'b1, AW'(DEPTH - 1), 16'hB002});
    exp_mem.push_back('{1'b1, AW'(0), 16'hB003});
    exp_mem.push_back('{1'b1, AW'(1), 16'hB004});
    send_cmd(1, DEPTH - 2, 3);
    for (int i = 0; i < 4; i++) send_wr(16'hB001 + WIDTH'(i));
    wdata_valid = 0;
    wait_done("wrap_done");
    chk("wrap_beats", 32'(mv_cnt - mv0), 4);
    chk("wrap_no_err", 32'(err_cnt - e0), 0);
`endif

    // 5: reset while holding beat 1 of an 8-beat read
    exp_mem.push_back('{1'b0, AW'('h010), last_wd});
    exp_rd.push_back('{16'hA001, 1'b0});
    send_cmd(0, 'h010, 7);
    begin
      logic got = 0;
      for (int k = 0; k < 50; k++) begin
        @(negedge clk);
        if (rdata_valid) begin got = 1; break; end
      end
      chk("rst_mid_valid", 32'(got), 1);
    end
    d0 = done_cnt;
    @(posedge clk); #1; reset = 1;
    @(negedge clk);
    @(negedge clk);
    chk("mid_rst_ready", 32'(cmd_ready), 1);
    chk("mid_rst_ctl", 32'({rdata_valid, rdata_last, done, busy, cmd_err, mem_valid, mem_wr, wdata_ready}), 0);
    chk("mid_rst_data", {rdata, mem_wdata}, 0);
    chk("mid_rst_addr", 32'(mem_addr), 0);
    reset = 0;
    last_wd = '0;
    exp_rd.delete();
    chk("mid_rst_no_done", 32'(done_cnt - d0), 0);
    chk("mid_rst_q", 32'(exp_mem.size()), 0);
    exp_mem.push_back('{1'b0, AW'('h012), last_wd});
    exp_rd.push_back('{16'hA003, 1'b1});
    rdata_ready = 1;
    send_cmd(0, 'h012, 0);
    wait_done("post_rst_done");

    // 6: cmd_valid held through a read burst, stray write data offered
    exp_mem.push_back('{1'b0, AW'('h020), last_wd});
    exp_mem.push_back('{1'b0, AW'('h021), last_wd});
    exp_rd.push_back('{pat('h020), 1'b0});
    exp_rd.push_back('{pat('h021), 1'b1});
    exp_mem.push_back('{1'b1, AW'('h030), 16'hDEAD});
    @(posedge clk); #1;
    cmd_valid = 1; cmd_wr = 0; cmd_addr = AW'('h020); cmd_len = LW'(1);
    wdata_valid = 1; wdata = 16'hDEAD;
    @(negedge clk);
    chk("hold_cmd_first", 32'(cmd_ready), 1);
    @(posedge clk); #1;
    cmd_wr = 1; cmd_addr = AW'('h030); cmd_len = LW'(0);
    rdy_cnt = 0;
    begin
      logic got = 0;
      for (int k = 0; k < 100; k++) begin
        @(negedge clk);
        if (done) begin got = 1; break; end
        if (cmd_ready) rdy_cnt++;
      end
      chk("hold_rd_done", 32'(got), 1);
    end
    chk("no_accept_busy", 32'(rdy_cnt), 0);
    @(negedge clk);
    chk("accept_after_done", 32'(cmd_ready), 1);
    @(posedge clk); #1; cmd_valid = 0;
    wait_done("hold_wr_done");
    wdata_valid = 0; rdata_ready = 0;

    @(negedge clk);
    chk("final_q", 32'(exp_mem.size() + exp_rd.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
